matrix_keypad_scanner: RTL and testbench
========================================

// Module: matrix_keypad_scanner
// PURPOSE
//  Parametrised ROWSxCOLS matrix keypad scanner with a programmable row dwell and a
//  frame-based debouncer. It reports multi-key conditions and issues press/release events
//  over a valid/ready interface to the downstream consumer (UI FSM or CPU register).
//  It sits between the keypad pins and the system logic.
// PARAMETERS
//  ROWS            4     number of row drive lines (>=2)
//  COLS            4     number of column sense lines (>=2)
//  SCAN_DIV        1000  clk cycles each row is driven (>=4)
//  DEBOUNCE_SCANS  4     consecutive identical frames needed to accept a change (>=1)
//  CODE_W          $clog2(ROWS*COLS)  key index width (derived, not overridden)
// PORTS
//  clk           in   1       system clock
//  reset_n       in   1       asynchronous reset, active low
//  col           in   COLS    column sense lines, active low, asynchronous to clk
//  row           out  ROWS    row drive, active-low one-hot
//  key_held      out  1       a single debounced key is currently down
//  key_code      out  CODE_W  index of the held key = row*COLS+col; holds its last value
//  multi_key     out  1       debounced state shows 2 or more keys down
//  evt_valid     out  1       event available
//  evt_ready     in   1       consumer accepts the event
//  evt_code      out  CODE_W  event key index
//  evt_press     out  1       1 = press event, 0 = release event
//  overflow      out  1       sticky flag: an event was dropped
//  overflow_clr  in   1       synchronous clear of overflow
// BEHAVIOUR
//  Reset (async on reset_n low) values:
//   - row index 0, dwell counter 0, so row = ~1 (row0 driven)
//   - key_held, multi_key, key_code, evt_valid, evt_code, evt_press, overflow = 0
//   - debounce state NONE, stable count 0, col synchronizer = all 1s
//  Reset may occur mid-frame: the partial frame is discarded and no event is produced.
//  Input synchronization: col passes through a 2-flop synchronizer (scol).
//  Scan:
//   - row r is driven for SCAN_DIV cycles
//   - scol is sampled on dwell count SCAN_DIV-1
//   - the row index then advances; after ROWS-1 it wraps to 0
//   - frame period = ROWS*SCAN_DIV cycles
//  Frame result, accumulated over the ROWS samples:
//   - NONE: 0 keys low
//   - SINGLE(k): exactly 1 key low
//   - MULTI: 2 or more keys low
//  Debounce, evaluated once per frame, in the cycle after the last-row sample:
//   - result equal to the previous frame's result: stable count increments, saturating
//   - result different: stable count resets to 1
//   - stable count reaching DEBOUNCE_SCANS with result != debounced state: the
//     debounced state takes the new result
//  Debounced-state transitions and resulting events (event visible next cycle):
//   NONE->SINGLE(k)       press k; key_held=1, key_code=k
//   SINGLE(k)->NONE       release k; key_held=0
//   SINGLE(k)->SINGLE(j)  press j only (release of k implied); key_code=j
//   SINGLE(k)->MULTI      release k; key_held=0, multi_key=1
//   MULTI->SINGLE(j)      press j; multi_key=0
//   MULTI->NONE           no event; multi_key=0
//  Event handshake:
//   - single-entry output register; an event transfers on evt_valid && evt_ready
//   - evt_valid, evt_code and evt_press are held stable until the transfer
//   - new event with the register empty, or with a transfer in the same cycle: loaded
//   - new event otherwise: dropped, overflow set
//   - overflow_clr and a new drop in the same cycle: overflow stays 1
//  Event rate: at most one new event per frame.
// TESTING
//  Defaults for all cases except case 6: ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE_SCANS=3
//  (frame = 32 cycles).
//  1. row mapping:
//     - drive col[1]=0 only while row[2]=0, evt_ready=1
//     - required: press evt_code=9 at the end of the 3rd stable frame, then key_held=1,
//       key_code=9
//     - release: one release event with code 9
//  2. bounce:
//     - toggle key 5 with a period of 1.5 frames for 10 frames
//     - required: no event; key_held stays 0
//  3. multi-key:
//     - hold key 0, then add key 15
//     - required: press 0, then release 0 with multi_key=1
//     - drop key 0: press 15, multi_key=0
//  4. backpressure:
//     - evt_ready=0; press and release key 3
//     - required: evt_valid=1 holding press 3, and overflow=1 after the release is dropped
//     - overflow_clr pulse: overflow=0
//  5. reset mid-frame:
//     - assert reset_n=0 during row 2 with key 6 held
//     - required: all outputs zero and row=4'b1110 immediately
//     - after reset: press 6 after 3 full frames
//  6. parameter variant:
//     - ROWS=3, COLS=5; press row2/col4
//     - required: evt_code=14; row cycles over 3 lines

Source files
------------

// File: rtl/matrix_keypad_scanner.sv
// Row-scanning keypad controller: drives one row at a time, classifies each full frame
// as none/single/multi, debounces frame results and reports press/release events.
module matrix_keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  localparam int CODE_W        = $clog2(ROWS*COLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic              key_held,
  output logic [CODE_W-1:0] key_code,
  output logic              multi_key,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_press,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {KIND_NONE, KIND_SINGLE, KIND_MULTI} kind_e;

  logic [COLS-1:0]   col_meta_q, scol_q;
  logic [RW-1:0]     row_idx_q;
  logic [DW-1:0]     dwell_q;
  logic [1:0]        acc_cnt_q;
  logic [CODE_W-1:0] acc_code_q;
  logic              frame_vld_q;
  kind_e             frame_kind_q;
  logic [CODE_W-1:0] frame_code_q;

  kind_e             prev_kind_q, prev_kind_d;
  logic [CODE_W-1:0] prev_code_q, prev_code_d;
  logic [CW-1:0]     stable_q, stable_d;
  kind_e             deb_kind_q, deb_kind_d;
  logic [CODE_W-1:0] deb_code_q, deb_code_d;
  logic              key_held_q, key_held_d;
  logic              multi_key_q, multi_key_d;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              evt_press_q, evt_press_d;
  logic              overflow_q, overflow_d;

  logic              new_evt, new_press;
  logic [CODE_W-1:0] new_code;
  logic [1:0]        row_hits, sample_cnt;
  logic [CODE_W-1:0] row_code, sample_code;
  logic [2:0]        hit_sum;

  assign row = ~(ROWS'(1) << row_idx_q);

  // Count low columns in the current row (saturating at 2) and merge with the frame so far.
  always_comb begin
    row_hits = 2'd0;
    row_code = '0;
    for (int c = 0; c < COLS; c++) begin
      if (!scol_q[c]) begin
        if (row_hits == 2'd0) row_code = CODE_W'(int'(row_idx_q) * COLS + c);
        if (row_hits != 2'd2) row_hits = row_hits + 2'd1;
      end
    end
    hit_sum     = {1'b0, acc_cnt_q} + {1'b0, row_hits};
    sample_cnt  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    sample_code = (acc_cnt_q == 2'd0 && row_hits == 2'd1) ? row_code : acc_code_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta_q   <= '1;
      scol_q       <= '1;
      row_idx_q    <= '0;
      dwell_q      <= '0;
      acc_cnt_q    <= 2'd0;
      acc_code_q   <= '0;
      frame_vld_q  <= 1'b0;
      frame_kind_q <= KIND_NONE;
      frame_code_q <= '0;
    end else begin
      col_meta_q  <= col;
      scol_q      <= col_meta_q;
      frame_vld_q <= 1'b0;
      if (dwell_q == DW'(SCAN_DIV - 1)) begin
        dwell_q <= '0;
        if (row_idx_q == RW'(ROWS - 1)) begin
          row_idx_q    <= '0;
          frame_vld_q  <= 1'b1;
          frame_kind_q <= (sample_cnt == 2'd0) ? KIND_NONE :
                          (sample_cnt == 2'd1) ? KIND_SINGLE : KIND_MULTI;
          // Non-single results carry code 0 so results compare on {kind, code}.
          frame_code_q <= (sample_cnt == 2'd1) ? sample_code : '0;
          acc_cnt_q    <= 2'd0;
          acc_code_q   <= '0;
        end else begin
          row_idx_q  <= row_idx_q + RW'(1);
          acc_cnt_q  <= sample_cnt;
          acc_code_q <= sample_code;
        end
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
    end
  end

  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_code_d = prev_code_q;
    stable_d    = stable_q;
    deb_kind_d  = deb_kind_q;
    deb_code_d  = deb_code_q;
    key_held_d  = key_held_q;
    multi_key_d = multi_key_q;
    key_code_d  = key_code_q;
    new_evt     = 1'b0;
    new_press   = 1'b0;
    new_code    = deb_code_q;
    if (frame_vld_q) begin
      prev_kind_d = frame_kind_q;
      prev_code_d = frame_code_q;
      if (frame_kind_q == prev_kind_q && frame_code_q == prev_code_q)
        stable_d = (stable_q == CW'(DEBOUNCE_SCANS)) ? stable_q : stable_q + CW'(1);
      else
        stable_d = CW'(1);
      if (stable_d == CW'(DEBOUNCE_SCANS) &&
          (frame_kind_q != deb_kind_q || frame_code_q != deb_code_q)) begin
        deb_kind_d  = frame_kind_q;
        deb_code_d  = frame_code_q;
        key_held_d  = (frame_kind_q == KIND_SINGLE);
        multi_key_d = (frame_kind_q == KIND_MULTI);
        case (frame_kind_q)
          KIND_SINGLE: begin
            new_evt    = 1'b1;
            new_press  = 1'b1;
            new_code   = frame_code_q;
            key_code_d = frame_code_q;
          end
          default: begin
            // Leaving a single key always reports its release; leaving multi does not.
            new_evt = (deb_kind_q == KIND_SINGLE);
          end
        endcase
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_press_d = evt_press_q;
    overflow_d  = overflow_q & ~overflow_clr;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (new_evt) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = new_code;
        evt_press_d = new_press;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_kind_q <= KIND_NONE;
      prev_code_q <= '0;
      stable_q    <= '0;
      deb_kind_q  <= KIND_NONE;
      deb_code_q  <= '0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
      key_code_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      evt_press_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      prev_kind_q <= prev_kind_d;
      prev_code_q <= prev_code_d;
      stable_q    <= stable_d;
      deb_kind_q  <= deb_kind_d;
      deb_code_q  <= deb_code_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
      key_code_q  <= key_code_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_press_q <= evt_press_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_held  = key_held_q;
  assign key_code  = key_code_q;
  assign multi_key = multi_key_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_press = evt_press_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Self-checking bench: keypad matrix model, event scoreboard, table of key patterns
// plus hand-written timing, bounce, backpressure, reset and parameter-variant sequences.
module tb_matrix_keypad_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [3:0]  col, row;
  logic        key_held, multi_key, evt_valid, evt_ready, evt_press, overflow, overflow_clr;
  logic [3:0]  key_code, evt_code;
  logic [15:0] keys;

  logic [4:0]  col6;
  logic [2:0]  row6;
  logic        key_held6, multi_key6, evt_valid6, evt_ready6, evt_press6, overflow6;
  logic [3:0]  key_code6, evt_code6;
  logic [14:0] keys6;

  matrix_keypad_scanner #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row), .key_held(key_held),
    .key_code(key_code), .multi_key(multi_key), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .overflow(overflow), .overflow_clr(overflow_clr));

  matrix_keypad_scanner #(.ROWS(3), .COLS(5), .SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut6 (
    .clk(clk), .reset_n(reset_n), .col(col6), .row(row6), .key_held(key_held6),
    .key_code(key_code6), .multi_key(multi_key6), .evt_valid(evt_valid6),
    .evt_ready(evt_ready6), .evt_code(evt_code6), .evt_press(evt_press6),
    .overflow(overflow6), .overflow_clr(1'b0));

  // Keypad: a pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always_comb begin
    col6 = '1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        if (keys6[r*5+c] && !row6[r]) col6[c] = 1'b0;
  end

  typedef struct {
    logic       press;
    logic [3:0] code;
  } evt_t;

  typedef struct {
    logic [15:0] keys;
    logic        ev;
    logic        press;
    logic [3:0]  code;
    logic        held;
    logic        multi;
    logic [3:0]  kcode;
  } step_t;

  evt_t  exp_q[$];
  step_t steps[11];
  int    checks = 0;
  int    errors = 0;
  int    evt_seen = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_evt(input logic press, input logic [3:0] code);
    evt_t e;
    e.press = press;
    e.code  = code;
    exp_q.push_back(e);
  endtask

  // One clock: observe handshakes on the falling edge, return 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    evt_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset_n && evt_valid && evt_ready) begin
        evt_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_event_code", int'(evt_code), -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_code", int'(evt_code), int'(e.code));
          chk("event_press", int'(evt_press), int'(e.press));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int n, seen0;
  logic [3:0] prev_row;
  logic [2:0] prev_row6;
  int bad_rot, row6_changes;

  initial begin
    steps[0]  = '{16'h0000, 1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 4'd9};
    steps[1]  = '{16'h0001, 1'b1, 1'b1, 4'd0,  1'b1, 1'b0, 4'd0};
    steps[2]  = '{16'h8001, 1'b1, 1'b0, 4'd0,  1'b0, 1'b1, 4'd0};
    steps[3]  = '{16'h8000, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0, 4'd15};
    steps[4]  = '{16'h0010, 1'b1, 1'b1, 4'd4,  1'b1, 1'b0, 4'd4};
    steps[5]  = '{16'h0000, 1'b1, 1'b0, 4'd4,  1'b0, 1'b0, 4'd4};
    steps[6]  = '{16'h0006, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd4};
    steps[7]  = '{16'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd4};
    steps[8]  = '{16'h0006, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd4};
    steps[9]  = '{16'h0004, 1'b1, 1'b1, 4'd2,  1'b1, 1'b0, 4'd2};
    steps[10] = '{16'h0000, 1'b1, 1'b0, 4'd2,  1'b0, 1'b0, 4'd2};

    reset_n = 1'b0; keys = '0; keys6 = '0;
    evt_ready = 1'b1; evt_ready6 = 1'b1; overflow_clr = 1'b0;
    tick(3);
    chk("reset_row", int'(row), 4'he);
    chk("reset_key_held", int'(key_held), 0);
    chk("reset_key_code", int'(key_code), 0);
    chk("reset_multi_key", int'(multi_key), 0);
    chk("reset_evt_valid", int'(evt_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    reset_n = 1'b1;
    tick(40);

    // Row mapping and debounce latency: key 9 (row 2, col 1) from a frame boundary.
    n = 0;
    do begin
      prev_row = row;
      tick();
      n++;
    end while (!(prev_row == 4'b0111 && row == 4'b1110) && n < 100);
    chk("frame_align_found", int'(n < 100), 1);
    keys = 16'h0200;
    push_evt(1'b1, 4'd9);
    seen0 = evt_seen;
    n = 0;
    while (evt_seen == seen0 && n < 200) begin
      tick();
      n++;
    end
    chk("press9_latency_in_window", int'(n >= 96 && n <= 100), 1);
    tick(2);
    chk("press9_key_held", int'(key_held), 1);
    chk("press9_key_code", int'(key_code), 9);

    for (int i = 0; i < 11; i++) begin
      keys = steps[i].keys;
      if (steps[i].ev) push_evt(steps[i].press, steps[i].code);
      tick(160);
      chk($sformatf("step%0d_key_held", i), int'(key_held), int'(steps[i].held));
      chk($sformatf("step%0d_multi_key", i), int'(multi_key), int'(steps[i].multi));
      chk($sformatf("step%0d_key_code", i), int'(key_code), int'(steps[i].kcode));
      chk($sformatf("step%0d_pending_events", i), exp_q.size(), 0);
    end

    // Bounce: key 5 toggles every 24 cycles (1.5-frame period) for about 10 frames.
    seen0 = evt_seen;
    for (int i = 0; i < 13; i++) begin
      keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
      tick(24);
      chk($sformatf("bounce%0d_key_held", i), int'(key_held), 0);
    end
    keys = '0;
    tick(160);
    chk("bounce_event_count", evt_seen - seen0, 0);

    // Backpressure: press 3 is held in the register, release 3 is dropped.
    evt_ready = 1'b0;
    keys = 16'h0008;
    tick(160);
    chk("bp_evt_valid", int'(evt_valid), 1);
    chk("bp_evt_code", int'(evt_code), 3);
    chk("bp_evt_press", int'(evt_press), 1);
    chk("bp_overflow_before_drop", int'(overflow), 0);
    keys = '0;
    tick(160);
    chk("bp_overflow_after_drop", int'(overflow), 1);
    chk("bp_held_evt_code", int'(evt_code), 3);
    chk("bp_held_evt_press", int'(evt_press), 1);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("bp_overflow_cleared", int'(overflow), 0);
    push_evt(1'b1, 4'd3);
    evt_ready = 1'b1;
    tick(3);
    chk("bp_drained_valid", int'(evt_valid), 0);
    chk("bp_drained_queue", exp_q.size(), 0);

    // Reset in the middle of row 2 with key 6 held.
    keys = 16'h0040;
    push_evt(1'b1, 4'd6);
    tick(160);
    chk("rst_pre_key_code", int'(key_code), 6);
    n = 0;
    while (row != 4'b1011 && n < 64) begin
      tick();
      n++;
    end
    chk("rst_row2_found", int'(row), 4'b1011);
    tick(3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_row", int'(row), 4'he);
    chk("rst_key_held", int'(key_held), 0);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_multi_key", int'(multi_key), 0);
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_code", int'(evt_code), 0);
    chk("rst_evt_press", int'(evt_press), 0);
    chk("rst_overflow", int'(overflow), 0);
    tick(3);
    reset_n = 1'b1;
    push_evt(1'b1, 4'd6);
    seen0 = evt_seen;
    n = 0;
    while (evt_seen == seen0 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_press6_latency_in_window", int'(n >= 96 && n <= 100), 1);
    keys = '0;
    push_evt(1'b0, 4'd6);
    tick(160);
    chk("rst_release6_queue", exp_q.size(), 0);

    // 3x5 variant: row cycling and key at row 2 / col 4.
    bad_rot = 0;
    row6_changes = 0;
    prev_row6 = row6;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (row6 != prev_row6) begin
        row6_changes++;
        if (row6 != {prev_row6[1:0], prev_row6[2]}) bad_rot++;
      end
      prev_row6 = row6;
    end
    chk("v6_row_rotation_errors", bad_rot, 0);
    chk("v6_row_changes_min", int'(row6_changes >= 6), 1);
    evt_ready6 = 1'b0;
    keys6 = 15'h4000;
    n = 0;
    while (!evt_valid6 && n < 400) begin
      tick();
      n++;
    end
    chk("v6_evt_valid", int'(evt_valid6), 1);
    chk("v6_evt_code", int'(evt_code6), 14);
    chk("v6_evt_press", int'(evt_press6), 1);
    tick(2);
    chk("v6_key_held", int'(key_held6), 1);
    chk("v6_key_code", int'(key_code6), 14);
    chk("v6_multi_key", int'(multi_key6), 0);
    chk("v6_overflow", int'(overflow6), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
